pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline's inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Inputs: hazard/miss/mispredict events from the stages.
- Outputs: per-register STALL/FLUSH plus a fetch redirect, resolved by fixed priority with a small FSM for multi-cycle events.
- Sits beside the pipeline registers. Each register gives FLUSH priority over STALL.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencer for the 5-stage pipeline, with a sticky stall watchdog.
// Define PIPE_HAZARD_CTRL_STATS_EN to add the stall-cycle and redirect statistics counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1023,
    parameter int CNT_W         = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ICACHE_MISS,
    input  logic             LOAD_USE,
    input  logic             MISPREDICT,
    input  logic [31:0]      MISPREDICT_PC,
    input  logic             DCACHE_MISS,
    output logic             STALL_PC,
    output logic             STALL_IFID,
    output logic             STALL_IDEX,
    output logic             STALL_EXMEM,
    output logic             STALL_MEMWB,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic             REDIRECT_VALID,
    output logic [31:0]      REDIRECT_PC,
    output logic             HANG,
    output logic [CNT_W-1:0] STALL_CYCLES_OUT,
    output logic [CNT_W-1:0] FLUSH_COUNT_OUT
);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2;
    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    logic [1:0]      state;
    logic            pend;
    logic [31:0]     pend_pc;
    logic [3:0]      cnt;
    logic [WD_W-1:0] wd;
    logic            in_redir, do_redir, do_lu, do_im;
    logic [31:0]     redir_pc;

    // A data-cache miss freezes everything; otherwise a pending or fresh mispredict wins,
    // and LOAD_USE/ICACHE_MISS only matter outside REDIRECT (they are wrong-path there).
    always_comb begin
        in_redir = state == REDIRECT;
        do_redir = 1'b0;
        redir_pc = MISPREDICT_PC;
        do_lu    = 1'b0;
        do_im    = 1'b0;
        if (!DCACHE_MISS) begin
            if (state == MEM_WAIT && pend) begin
                do_redir = 1'b1;
                redir_pc = pend_pc;
            end else if (MISPREDICT) begin
                do_redir = 1'b1;
            end else if (!in_redir) begin
                do_lu = LOAD_USE;
                do_im = !LOAD_USE && ICACHE_MISS;
            end
        end
    end

    assign STALL_PC       = RESET && (DCACHE_MISS || do_lu || do_im);
    assign STALL_IFID     = RESET && (DCACHE_MISS || do_lu);
    assign STALL_IDEX     = RESET && DCACHE_MISS;
    assign STALL_EXMEM    = RESET && DCACHE_MISS;
    assign STALL_MEMWB    = RESET && DCACHE_MISS;
    assign FLUSH_IFID     = RESET && (do_redir || do_im || in_redir);
    assign FLUSH_IDEX     = RESET && (do_redir || do_lu);
    assign REDIRECT_VALID = RESET && do_redir;
    assign REDIRECT_PC    = (RESET && do_redir) ? redir_pc : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= RUN;
            pend    <= 1'b0;
            pend_pc <= '0;
            cnt     <= '0;
            wd      <= '0;
            HANG    <= 1'b0;
        end else begin
            if (DCACHE_MISS) begin
                if (MISPREDICT) begin
                    pend    <= 1'b1;
                    pend_pc <= MISPREDICT_PC;
                    state   <= MEM_WAIT;
                end else if (state == RUN) begin
                    state <= MEM_WAIT;
                end
            end else if (do_redir) begin
                pend  <= 1'b0;
                cnt   <= FC;
                state <= (FC == 4'd0) ? RUN : REDIRECT;
            end else if (in_redir) begin
                cnt <= cnt - 4'd1;
                if (cnt <= 4'd1) state <= RUN;
            end else begin
                state <= RUN;
            end
            wd <= STALL_PC ? ((wd == WD_MAX) ? wd : wd + 1'b1) : '0;
            if (STALL_PC && wd >= WD_MAX - 1'b1) HANG <= 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [CNT_W-1:0] st_cnt, fl_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            st_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            st_cnt <= st_cnt + CNT_W'(STALL_PC);
            fl_cnt <= fl_cnt + CNT_W'(REDIRECT_VALID);
        end
    end

    assign STALL_CYCLES_OUT = st_cnt;
    assign FLUSH_COUNT_OUT  = fl_cnt;
`else
    assign STALL_CYCLES_OUT = '0;
    assign FLUSH_COUNT_OUT  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench; each driven cycle queues its expected outputs, checked at negedge.
module tb_pipe_hazard_ctrl;
    localparam int TO = 8;
    localparam logic [7:0] NONE = 8'b00000_000, ALLS = 8'b11111_000, LU = 8'b11000_010,
                           MP = 8'b00000_111, FI = 8'b00000_100, IM = 8'b10000_100;
    localparam logic [31:0] PA = 32'h0040_0120, PB = 32'h0040_0200, PC3 = 32'h0040_0ABC;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] pc;
        logic        hang;
        logic [31:0] st;
        logic [31:0] fl;
    } exp_t;

    logic CLK = 0, RESET = 0, ICACHE_MISS = 0, LOAD_USE = 0, MISPREDICT = 0, DCACHE_MISS = 0;
    logic [31:0] MISPREDICT_PC = '0;
    logic STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB, FLUSH_IFID, FLUSH_IDEX;
    logic REDIRECT_VALID, HANG;
    logic [31:0] REDIRECT_PC, STALL_CYCLES_OUT, FLUSH_COUNT_OUT;

    exp_t exp_q[$];
    int n_cmp = 0, n_err = 0;
    int m_wd = 0;
    logic m_hang = 0;
    logic [31:0] m_st = 0, m_fl = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(TO), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .ICACHE_MISS(ICACHE_MISS), .LOAD_USE(LOAD_USE),
        .MISPREDICT(MISPREDICT), .MISPREDICT_PC(MISPREDICT_PC), .DCACHE_MISS(DCACHE_MISS),
        .STALL_PC(STALL_PC), .STALL_IFID(STALL_IFID), .STALL_IDEX(STALL_IDEX),
        .STALL_EXMEM(STALL_EXMEM), .STALL_MEMWB(STALL_MEMWB), .FLUSH_IFID(FLUSH_IFID),
        .FLUSH_IDEX(FLUSH_IDEX), .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
        .HANG(HANG), .STALL_CYCLES_OUT(STALL_CYCLES_OUT), .FLUSH_COUNT_OUT(FLUSH_COUNT_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".ctl"}, 64'({STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB,
                                      FLUSH_IFID, FLUSH_IDEX, REDIRECT_VALID}), 64'(e.ctl));
            chk({e.tag, ".pc"}, 64'(REDIRECT_PC), 64'(e.pc));
            chk({e.tag, ".hang"}, 64'(HANG), 64'(e.hang));
            chk({e.tag, ".stats"}, {STALL_CYCLES_OUT, FLUSH_COUNT_OUT}, {e.st, e.fl});
        end
    end

    // Drive one cycle just after the edge and queue what the outputs must read this cycle.
    task automatic step(input string tag, input logic rst, im, lu, mp, input logic [31:0] mpc,
                        input logic dm, input logic [7:0] ec, input logic [31:0] epc);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET = rst; ICACHE_MISS = im; LOAD_USE = lu; MISPREDICT = mp; MISPREDICT_PC = mpc;
        DCACHE_MISS = dm;
        e.tag = tag; e.ctl = ec; e.pc = epc;
        e.hang = rst ? m_hang : 1'b0;
        e.st = rst ? m_st : 32'd0;
        e.fl = rst ? m_fl : 32'd0;
        exp_q.push_back(e);
        if (rst) begin
            m_wd = ec[7] ? ((m_wd < TO) ? m_wd + 1 : m_wd) : 0;
            if (m_wd >= TO) m_hang = 1'b1;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
            m_st = m_st + 32'(ec[7]);
            m_fl = m_fl + 32'(ec[0]);
`endif
        end else begin
            m_wd = 0; m_hang = 1'b0; m_st = 0; m_fl = 0;
        end
    endtask

    initial begin
        step("reset",      0, 0, 0, 0, 0,   0, NONE, 0);
        step("idle0",      1, 0, 0, 0, 0,   0, NONE, 0);
        step("lu",         1, 0, 1, 0, 0,   0, LU,   0);
        step("lu_after",   1, 0, 0, 0, 0,   0, NONE, 0);
        step("mp_c0",      1, 0, 0, 1, PA,  0, MP,   PA);
        step("mp_c1",      1, 0, 0, 0, 0,   0, FI,   0);
        step("mp_c2",      1, 0, 0, 0, 0,   0, NONE, 0);
        step("im_lu",      1, 1, 1, 0, 0,   0, LU,   0);
        step("im",         1, 1, 0, 0, 0,   0, IM,   0);
        step("dm_mp0",     1, 0, 0, 1, PB,  1, ALLS, 0);
        step("dm1",        1, 0, 0, 0, 0,   1, ALLS, 0);
        step("dm2",        1, 0, 0, 0, 0,   1, ALLS, 0);
        step("pend_redir", 1, 0, 0, 0, 0,   0, MP,   PB);
        step("pend_flush", 1, 0, 0, 0, 0,   0, FI,   0);
        step("pend_idle",  1, 0, 0, 0, 0,   0, NONE, 0);
        step("rd_ign0",    1, 0, 0, 1, PA,  0, MP,   PA);
        step("rd_ign1",    1, 1, 1, 0, 0,   0, FI,   0);
        step("rd_ign2",    1, 0, 0, 0, 0,   0, NONE, 0);
        step("rd_new0",    1, 0, 0, 1, PA,  0, MP,   PA);
        step("rd_new1",    1, 0, 0, 1, PC3, 0, MP,   PC3);
        step("rd_new2",    1, 0, 0, 0, 0,   0, FI,   0);
        step("rd_new3",    1, 0, 0, 0, 0,   0, NONE, 0);
        step("rd_dm0",     1, 0, 0, 1, PA,  0, MP,   PA);
        step("rd_dm1",     1, 0, 0, 0, 0,   1, 8'b11111_100, 0);
        step("rd_dm2",     1, 0, 0, 0, 0,   0, FI,   0);
        step("rd_dm3",     1, 0, 0, 0, 0,   0, NONE, 0);
        step("mw_lu0",     1, 0, 0, 0, 0,   1, ALLS, 0);
        step("mw_lu1",     1, 0, 1, 0, 0,   0, LU,   0);
        step("mw_lu2",     1, 0, 0, 0, 0,   0, NONE, 0);
        step("mw_late0",   1, 0, 0, 1, PA,  1, ALLS, 0);
        step("mw_late1",   1, 0, 0, 1, PB,  1, ALLS, 0);
        step("mw_late2",   1, 0, 0, 0, 0,   0, MP,   PB);
        step("mw_late3",   1, 0, 0, 0, 0,   0, FI,   0);
        step("mw_late4",   1, 0, 0, 0, 0,   0, NONE, 0);
        for (int i = 0; i < 10; i++) step("hang_dm", 1, 0, 0, 0, 0, 1, ALLS, 0);
        step("hang_sticky0", 1, 0, 0, 0, 0, 0, NONE, 0);
        step("hang_sticky1", 1, 0, 0, 0, 0, 0, NONE, 0);
        step("rst_rd0",    1, 0, 0, 1, PA,  0, MP,   PA);
        step("rst_rd1",    0, 1, 1, 0, 0,   0, NONE, 0);
        step("rst_rd2",    1, 0, 0, 0, 0,   0, NONE, 0);
        step("rst_mw0",    1, 0, 0, 1, PB,  1, ALLS, 0);
        step("rst_mw1",    1, 0, 0, 0, 0,   1, ALLS, 0);
        step("rst_mw2",    0, 0, 0, 0, 0,   1, NONE, 0);
        step("rst_mw3",    1, 0, 0, 0, 0,   0, NONE, 0);
        step("rst_mw4",    1, 0, 0, 0, 0,   0, NONE, 0);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
